// File: rtl/adder_tree_pkg.sv
// Shared types and helpers for the adder-tree return path.
package adder_tree_pkg;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_FIRST,
        SER_SECOND
    } ser_state_t;

    // Width of a packed {term_a, term_b} pair for a given term width.
    function automatic int pair_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// Small synchronous FIFO holding packed term pairs for the serializer.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module pair_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pair_serializer.sv
// Buffers (term_a, term_b) pairs and emits them as a serial stream of
// single terms, optionally term_b first to undo the upstream swap.
module pair_serializer
    import adder_tree_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter bit FIRST_TERM_B = 1'b1
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_pair_valid,
    output logic                            o_pair_ready,
    input  logic [WIDTH-1:0]                i_term_a,
    input  logic [WIDTH-1:0]                i_term_b,
    output logic                            o_term_valid,
    input  logic                            i_term_ready,
    output logic [WIDTH-1:0]                o_term,
    output logic                            o_term_last,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_count
);

    localparam int PAIR_WIDTH = pair_w(WIDTH);

    ser_state_t            state;
    logic [WIDTH-1:0]      hold_a;
    logic [WIDTH-1:0]      hold_b;
    logic [PAIR_WIDTH-1:0] rd_data;
    logic [WIDTH-1:0]      rd_a;
    logic [WIDTH-1:0]      rd_b;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Ready comes from the registered FIFO count only, so it never depends on i_term_ready.
    assign o_pair_ready = !full;
    assign push         = i_pair_valid && !full;
    assign rd_a         = rd_data[PAIR_WIDTH-1:WIDTH];
    assign rd_b         = rd_data[WIDTH-1:0];

    pair_fifo #(
        .WIDTH (PAIR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_pair_fifo (
        .clock     (i_clock),
        .reset     (i_reset),
        .push      (push),
        .push_data ({i_term_a, i_term_b}),
        .pop       (pop),
        .rd_data   (rd_data),
        .full      (full),
        .empty     (empty),
        .count     (o_fifo_count)
    );

    // Pop a new pair whenever the hold register is free or about to be freed by the last term.
    always_comb begin
        pop = 1'b0;
        case (state)
            SER_IDLE:   pop = !empty;
            SER_SECOND: pop = i_term_ready && !empty;
            default:    pop = 1'b0;
        endcase
    end

    // Output FSM: loads the hold register and drives registered term outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= SER_IDLE;
            hold_a       <= '0;
            hold_b       <= '0;
            o_term_valid <= 1'b0;
            o_term       <= '0;
            o_term_last  <= 1'b0;
        end else begin
            case (state)
                SER_IDLE: begin
                    if (pop) begin
                        hold_a       <= rd_a;
                        hold_b       <= rd_b;
                        o_term       <= FIRST_TERM_B ? rd_b : rd_a;
                        o_term_valid <= 1'b1;
                        o_term_last  <= 1'b0;
                        state        <= SER_FIRST;
                    end
                end
                SER_FIRST: begin
                    if (i_term_ready) begin
                        o_term      <= FIRST_TERM_B ? hold_a : hold_b;
                        o_term_last <= 1'b1;
                        state       <= SER_SECOND;
                    end
                end
                SER_SECOND: begin
                    if (i_term_ready) begin
                        if (pop) begin
                            hold_a       <= rd_a;
                            hold_b       <= rd_b;
                            o_term       <= FIRST_TERM_B ? rd_b : rd_a;
                            o_term_valid <= 1'b1;
                            o_term_last  <= 1'b0;
                            state        <= SER_FIRST;
                        end else begin
                            o_term       <= '0;
                            o_term_valid <= 1'b0;
                            o_term_last  <= 1'b0;
                            state        <= SER_IDLE;
                        end
                    end
                end
                default: begin
                    state <= SER_IDLE;
                end
            endcase
        end
    end

endmodule
